// File: rtl/input_controller.sv
// Pushbutton front end: synchronise, debounce, map presses to game commands, valid/ready handoff.
// Optional HIT auto-repeat is compiled in when INPUT_CTRL_AUTOREPEAT_EN is defined.
module input_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_CYCLES   = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key_n,
   output logic       cmd_valid,
   output logic [1:0] cmd,
   input  logic       cmd_ready,
   output logic       cmd_dropped,
   output logic [3:0] keys_held
);

   localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic {
      IDLE,
      PEND
   } ctrlState;

   logic [3:0]      syncMeta;
   logic [3:0]      syncOut;
   logic [3:0]      pressedSync;
   logic [3:0]      keysHeld;
   logic [3:0]      keysPrev;
   logic [CntW-1:0] dbCnt [4];

   logic [3:0] pressEvt;
   logic [3:0] evt;
   logic       repeatEvt;
   logic       multiEvt;
   logic       handshake;
   logic [1:0] winner;

   ctrlState   state;
   ctrlState   stateNext;
   logic [1:0] cmdReg;
   logic [1:0] cmdNext;
   logic       dropReg;
   logic       dropNext;

   assign pressedSync = ~syncOut;

   // Synchronisers idle at the released level so reset release never looks like a press.
   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the debounce counters are per-key flops, not RAM, so they are reset like any register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncMeta <= 4'hF;
         syncOut  <= 4'hF;
         keysHeld <= 4'h0;
         keysPrev <= 4'h0;
         for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
      end else begin
         syncMeta <= key_n;
         syncOut  <= syncMeta;
         keysPrev <= keysHeld;
         for (int i = 0; i < 4; i++) begin
            if (pressedSync[i] == keysHeld[i]) begin
               dbCnt[i] <= '0;
            end else if (dbCnt[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
               keysHeld[i] <= ~keysHeld[i];
               dbCnt[i]    <= '0;
            end else begin
               dbCnt[i] <= dbCnt[i] + CntW'(1);
            end
         end
      end
   end

`ifdef INPUT_CTRL_AUTOREPEAT_EN
   localparam int RptW = $clog2(REPEAT_CYCLES + 1);

   logic [RptW-1:0] rptCnt;
   logic            hitOnly;

   assign hitOnly = (keysHeld == 4'b0001);

   // Counter sits at 0 on the press edge; it restarts at 1 after each fire so the period stays REPEAT_CYCLES.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptCnt <= '0;
      end else if (!hitOnly) begin
         rptCnt <= '0;
      end else if (rptCnt == RptW'(REPEAT_CYCLES)) begin
         rptCnt <= RptW'(1);
      end else begin
         rptCnt <= rptCnt + RptW'(1);
      end
   end

   assign repeatEvt = hitOnly && (rptCnt == RptW'(REPEAT_CYCLES));
`else
   localparam int unusedRepeatCycles = REPEAT_CYCLES;
   assign repeatEvt = 1'b0;
`endif

   assign pressEvt  = keysHeld & ~keysPrev;
   assign evt       = pressEvt | {3'b000, repeatEvt};
   assign multiEvt  = (evt & (evt - 4'd1)) != 4'd0;
   assign handshake = (state == PEND) && cmd_ready;
   assign winner    = evt[3] ? 2'b11 :
                      evt[2] ? 2'b10 :
                      evt[1] ? 2'b01 : 2'b00;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      stateNext = state;
      cmdNext   = cmdReg;
      dropNext  = 1'b0;
      case (state)
         IDLE: begin
            if (|evt) begin
               stateNext = PEND;
               cmdNext   = winner;
               dropNext  = multiEvt;
            end
         end
         PEND: begin
            if (handshake) begin
               if (|evt) begin
                  cmdNext  = winner;
                  dropNext = multiEvt;
               end else begin
                  stateNext = IDLE;
               end
            end else if (evt[3] && (cmdReg != 2'b11)) begin
               // NEWGAME pre-empts a stale pending command instead of being lost.
               cmdNext  = 2'b11;
               dropNext = |evt[2:0];
            end else if (|evt) begin
               dropNext = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cmdReg  <= 2'b00;
         dropReg <= 1'b0;
      end else begin
         state   <= stateNext;
         cmdReg  <= cmdNext;
         dropReg <= dropNext;
      end
   end

   assign cmd_valid   = (state == PEND);
   assign cmd         = cmdReg;
   assign cmd_dropped = dropReg;
   assign keys_held   = keysHeld;

endmodule

// File: tb/tb_input_controller.sv
// Self-checking bench for input_controller with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
// The auto-repeat scenario runs only when INPUT_CTRL_AUTOREPEAT_EN is defined.
module tb_input_controller;

   localparam int DEB = 4;
   localparam int RPT = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_n = 4'hF;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       cmd_dropped;
   logic [3:0] keys_held;

   int total = 0;
   int bad = 0;
   int dropCnt = 0;
   logic [1:0] gotQ[$];
   logic [1:0] expQ[$];

   input_controller #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_n(key_n),
      .cmd_valid(cmd_valid),
      .cmd(cmd),
      .cmd_ready(cmd_ready),
      .cmd_dropped(cmd_dropped),
      .keys_held(keys_held)
   );

   always #5 clk = ~clk;

   // Accepted commands and drop pulses, sampled mid-cycle ahead of the edge that completes them.
   always @(negedge clk) begin
      if (cmd_valid && cmd_ready) gotQ.push_back(cmd);
      if (cmd_dropped) dropCnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(2);
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", cmd_valid); end
      total++; if (cmd !== 2'b00) begin bad++; $display("FAIL rst_cmd got=%b want=00", cmd); end
      total++; if (cmd_dropped !== 1'b0) begin bad++; $display("FAIL rst_dropped got=%b want=0", cmd_dropped); end
      total++; if (keys_held !== 4'b0000) begin bad++; $display("FAIL rst_keys got=%b want=0000", keys_held); end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_single_hit();
      int gs, firstEdge, validCnt;
      logic validAt8;
      gs = gotQ.size(); firstEdge = -1; validCnt = 0; validAt8 = 1'bx;
      cmd_ready = 1'b1;
      key_n = 4'b1110;
      expQ.push_back(2'b00);
      for (int e = 1; e <= 30; e++) begin
         if (e == 16) key_n = 4'hF;
         tick(1);
         if (cmd_valid) begin
            validCnt++;
            if (firstEdge < 0) firstEdge = e;
         end
         if (e == 8) validAt8 = cmd_valid;
      end
      total++; if (firstEdge != DEB + 3) begin bad++; $display("FAIL hit_latency got=%0d want=%0d", firstEdge, DEB + 3); end
      total++; if (validAt8 !== 1'b0) begin bad++; $display("FAIL hit_valid_fall got=%b want=0", validAt8); end
      total++; if (validCnt != 1) begin bad++; $display("FAIL hit_once got=%0d want=1", validCnt); end
      total++; if (keys_held !== 4'b0000) begin bad++; $display("FAIL hit_release got=%b want=0000", keys_held); end
      total++; if (gotQ.size() - gs != expQ.size()) begin bad++; $display("FAIL hit_count got=%0d want=%0d", gotQ.size() - gs, expQ.size()); end
      for (int k = 0; expQ.size() > 0; k++) begin
         logic [1:0] e;
         e = expQ.pop_front();
         if (gs + k < gotQ.size()) begin
            total++; if (gotQ[gs + k] !== e) begin bad++; $display("FAIL hit_cmd got=%b want=%b", gotQ[gs + k], e); end
         end
      end
   endtask

   task automatic test_glitch();
      int gs, d0;
      logic sawHeld, sawValid;
      gs = gotQ.size(); d0 = dropCnt; sawHeld = 1'b0; sawValid = 1'b0;
      cmd_ready = 1'b1;
      key_n = 4'b1101;
      for (int e = 1; e <= 18; e++) begin
         if (e == 4) key_n = 4'hF;
         tick(1);
         sawHeld  = sawHeld | (|keys_held);
         sawValid = sawValid | cmd_valid;
      end
      total++; if (sawHeld !== 1'b0) begin bad++; $display("FAIL glitch_held got=%b want=0", sawHeld); end
      total++; if (sawValid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b want=0", sawValid); end
      total++; if (dropCnt - d0 != 0) begin bad++; $display("FAIL glitch_drop got=%0d want=0", dropCnt - d0); end
      total++; if (gotQ.size() - gs != expQ.size()) begin bad++; $display("FAIL glitch_count got=%0d want=%0d", gotQ.size() - gs, expQ.size()); end
   endtask

   task automatic test_min_press();
      int gs;
      gs = gotQ.size();
      cmd_ready = 1'b1;
      key_n = 4'b1101;
      expQ.push_back(2'b01);
      tick(DEB);
      key_n = 4'hF;
      tick(20);
      total++; if (gotQ.size() - gs != expQ.size()) begin bad++; $display("FAIL minpress_count got=%0d want=%0d", gotQ.size() - gs, expQ.size()); end
      for (int k = 0; expQ.size() > 0; k++) begin
         logic [1:0] e;
         e = expQ.pop_front();
         if (gs + k < gotQ.size()) begin
            total++; if (gotQ[gs + k] !== e) begin bad++; $display("FAIL minpress_cmd got=%b want=%b", gotQ[gs + k], e); end
         end
      end
   endtask

   task automatic test_simultaneous();
      int gs, d0;
      gs = gotQ.size(); d0 = dropCnt;
      cmd_ready = 1'b1;
      key_n = 4'b1010;
      expQ.push_back(2'b10);
      tick(15);
      key_n = 4'hF;
      tick(12);
      total++; if (dropCnt - d0 != 1) begin bad++; $display("FAIL simul_drop got=%0d want=1", dropCnt - d0); end
      total++; if (gotQ.size() - gs != expQ.size()) begin bad++; $display("FAIL simul_count got=%0d want=%0d", gotQ.size() - gs, expQ.size()); end
      for (int k = 0; expQ.size() > 0; k++) begin
         logic [1:0] e;
         e = expQ.pop_front();
         if (gs + k < gotQ.size()) begin
            total++; if (gotQ[gs + k] !== e) begin bad++; $display("FAIL simul_cmd got=%b want=%b", gotQ[gs + k], e); end
         end
      end
   endtask

   task automatic test_pending_overwrite();
      int gs, d0;
      logic seen;
      gs = gotQ.size(); d0 = dropCnt; seen = 1'b0;
      cmd_ready = 1'b0;
      key_n = 4'b1110;
      for (int n = 0; n < 20 && !seen; n++) begin tick(1); seen = cmd_valid; end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL ovr_pending got=%b want=1", seen); end
      key_n = 4'hF;
      tick(10);
      key_n = 4'b1101;
      tick(12);
      total++; if (dropCnt - d0 != 1) begin bad++; $display("FAIL ovr_stand_drop got=%0d want=1", dropCnt - d0); end
      total++; if (cmd !== 2'b00 || cmd_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold got=%b/%b want=00/1", cmd, cmd_valid); end
      key_n = 4'b0101;
      tick(12);
      total++; if (cmd !== 2'b11) begin bad++; $display("FAIL ovr_newgame got=%b want=11", cmd); end
      total++; if (dropCnt - d0 != 1) begin bad++; $display("FAIL ovr_no_extra_drop got=%0d want=1", dropCnt - d0); end
      expQ.push_back(2'b11);
      cmd_ready = 1'b1;
      tick(1);
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%b want=0", cmd_valid); end
      key_n = 4'hF;
      tick(12);
      total++; if (gotQ.size() - gs != expQ.size()) begin bad++; $display("FAIL ovr_count got=%0d want=%0d", gotQ.size() - gs, expQ.size()); end
      for (int k = 0; expQ.size() > 0; k++) begin
         logic [1:0] e;
         e = expQ.pop_front();
         if (gs + k < gotQ.size()) begin
            total++; if (gotQ[gs + k] !== e) begin bad++; $display("FAIL ovr_cmd got=%b want=%b", gotQ[gs + k], e); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int gs;
      logic seen;
      gs = gotQ.size(); seen = 1'b0;
      cmd_ready = 1'b0;
      key_n = 4'b1110;
      for (int n = 0; n < 20 && !seen; n++) begin tick(1); seen = cmd_valid; end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL b2b_pending got=%b want=1", seen); end
      expQ.push_back(2'b00);
      expQ.push_back(2'b01);
      key_n = 4'hF;
      tick(10);
      key_n = 4'b1101;
      tick(DEB + 2);
      cmd_ready = 1'b1;
      tick(1);
      total++; if (cmd_valid !== 1'b1 || cmd !== 2'b01) begin bad++; $display("FAIL b2b_reload got=%b/%b want=1/01", cmd_valid, cmd); end
      tick(1);
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL b2b_fall got=%b want=0", cmd_valid); end
      key_n = 4'hF;
      tick(12);
      total++; if (gotQ.size() - gs != expQ.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", gotQ.size() - gs, expQ.size()); end
      for (int k = 0; expQ.size() > 0; k++) begin
         logic [1:0] e;
         e = expQ.pop_front();
         if (gs + k < gotQ.size()) begin
            total++; if (gotQ[gs + k] !== e) begin bad++; $display("FAIL b2b_cmd got=%b want=%b", gotQ[gs + k], e); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int gs, firstEdge;
      logic seen;
      gs = gotQ.size(); seen = 1'b0;
      cmd_ready = 1'b0;
      key_n = 4'b1110;
      for (int n = 0; n < 20 && !seen; n++) begin tick(1); seen = cmd_valid; end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_pending got=%b want=1", seen); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b want=0", cmd_valid); end
      key_n = 4'hF;
      tick(2);
      rst_n = 1'b1;
      cmd_ready = 1'b1;
      seen = 1'b0;
      repeat (20) begin tick(1); seen = seen | cmd_valid; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_ghost got=%b want=0", seen); end
      // Key held across reset release must come back as a fresh press.
      rst_n = 1'b0;
      key_n = 4'b1110;
      tick(2);
      rst_n = 1'b1;
      expQ.push_back(2'b00);
      firstEdge = -1;
      for (int e = 1; e <= 20 && firstEdge < 0; e++) begin tick(1); if (cmd_valid) firstEdge = e; end
      total++; if (firstEdge != DEB + 3) begin bad++; $display("FAIL rstmid_held_latency got=%0d want=%0d", firstEdge, DEB + 3); end
      key_n = 4'hF;
      tick(12);
      total++; if (gotQ.size() - gs != expQ.size()) begin bad++; $display("FAIL rstmid_count got=%0d want=%0d", gotQ.size() - gs, expQ.size()); end
      for (int k = 0; expQ.size() > 0; k++) begin
         logic [1:0] e;
         e = expQ.pop_front();
         if (gs + k < gotQ.size()) begin
            total++; if (gotQ[gs + k] !== e) begin bad++; $display("FAIL rstmid_cmd got=%b want=%b", gotQ[gs + k], e); end
         end
      end
   endtask

`ifdef INPUT_CTRL_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int gs;
      int hits[$];
      int want[3];
      gs = gotQ.size();
      want[0] = DEB + 3;
      want[1] = DEB + 3 + RPT;
      want[2] = DEB + 3 + 2 * RPT;
      cmd_ready = 1'b1;
      key_n = 4'b1110;
      for (int e = 1; e <= 90; e++) begin
         tick(1);
         if (e == 60) key_n = 4'hF;
         if (cmd_valid) hits.push_back(e);
      end
      total++; if (hits.size() != 3) begin bad++; $display("FAIL rpt_count got=%0d want=3", hits.size()); end
      for (int k = 0; k < 3 && k < hits.size(); k++) begin
         total++; if (hits[k] != want[k]) begin bad++; $display("FAIL rpt_edge%0d got=%0d want=%0d", k, hits[k], want[k]); end
      end
      repeat (3) expQ.push_back(2'b00);
      total++; if (gotQ.size() - gs != expQ.size()) begin bad++; $display("FAIL rpt_sb_count got=%0d want=%0d", gotQ.size() - gs, expQ.size()); end
      for (int k = 0; expQ.size() > 0; k++) begin
         logic [1:0] e;
         e = expQ.pop_front();
         if (gs + k < gotQ.size()) begin
            total++; if (gotQ[gs + k] !== e) begin bad++; $display("FAIL rpt_cmd got=%b want=%b", gotQ[gs + k], e); end
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_hit();
      test_glitch();
      test_min_press();
      test_simultaneous();
      test_pending_overwrite();
      test_back_to_back();
      test_reset_mid();
`ifdef INPUT_CTRL_AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
